// File: rtl/reg_dump_printer.sv
// -----------------------------------------------------------------------------
// reg_dump_printer
//
// Walks the register file debug read port and prints every register as eight
// uppercase hex characters into an ASCII frame buffer, one register per text
// row starting at BASE_ROW. Each register costs 11 cycles:
// READ (1), LATCH (1), EMIT (8), NEXT (1).
//
// Parameters
//   COLS      character cells per text row
//   NUM_REGS  number of registers dumped (indices 0..NUM_REGS-1)
//   BASE_ROW  screen row that receives register 0
//   ATTR      colour/attribute bits placed in ascii_input[23:0]
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   rst                  asynchronous, active-low reset
//   start                request a full dump (sampled in IDLE only)
//   abort                cancel a dump in progress (highest priority)
//   debug_reg            register index for the debug read port
//   debug_reg_out        debug read data, valid one cycle after debug_reg moves
//   ascii_write_en       one character written per high cycle
//   ascii_write_address  character cell address
//   ascii_input          {ASCII code, ATTR}
//   busy                 high from the first READ cycle through DONE
//   done                 single-cycle completion pulse
// -----------------------------------------------------------------------------
module reg_dump_printer #(
    parameter int unsigned COLS     = 80,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned BASE_ROW = 0,
    parameter logic [23:0] ATTR     = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  debug_reg,
    input  logic [31:0] debug_reg_out,
    output logic        ascii_write_en,
    output logic [12:0] ascii_write_address,
    output logic [31:0] ascii_input,
    output logic        busy,
    output logic        done
);

    // Index register is at least 5 bits so debug_reg is always a plain slice.
    localparam int unsigned RW = (NUM_REGS > 32) ? $clog2(NUM_REGS) : 5;
    localparam logic [RW-1:0] LAST_IDX = RW'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [RW-1:0]  r_reg_idx;
    logic [2:0]     r_nib_idx;
    logic [31:0]    r_word;
    logic [4:0]     r_debug_reg;

    logic [RW-1:0]  w_idx_inc;
    logic [3:0]     w_nibble;
    logic [7:0]     w_char;
    logic [12:0]    w_row;
    logic [12:0]    w_addr;

    // -------------------------------------------------------------------------
    // Hex digit to uppercase ASCII
    // -------------------------------------------------------------------------
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic; abort overrides everything, including a start in IDLE
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_READ;
                S_READ:  w_next = S_LATCH;
                S_LATCH: w_next = S_EMIT;
                S_EMIT:  if (r_nib_idx == 3'd7) w_next = S_NEXT;
                S_NEXT:  w_next = (r_reg_idx == LAST_IDX) ? S_DONE : S_READ;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign w_idx_inc = r_reg_idx + RW'(1);

    // -------------------------------------------------------------------------
    // Datapath registers. debug_reg is loaded on the edge that enters READ so
    // it already equals reg_idx during READ, and the read data is valid during
    // LATCH, where it is captured. It is left untouched in IDLE and DONE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_idx   <= '0;
            r_nib_idx   <= '0;
            r_word      <= '0;
            r_debug_reg <= '0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_reg_idx   <= '0;
                        r_debug_reg <= '0;
                    end
                end
                S_LATCH: begin
                    r_word    <= debug_reg_out;
                    r_nib_idx <= '0;
                end
                S_EMIT: begin
                    if (r_nib_idx != 3'd7) begin
                        r_nib_idx <= r_nib_idx + 3'd1;
                    end
                end
                S_NEXT: begin
                    if (r_reg_idx != LAST_IDX) begin
                        r_reg_idx   <= w_idx_inc;
                        r_debug_reg <= w_idx_inc[4:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Character generation: most significant nibble first
    // -------------------------------------------------------------------------
    always_comb begin
        w_nibble = r_word[31:28];
        case (r_nib_idx)
            3'd0: w_nibble = r_word[31:28];
            3'd1: w_nibble = r_word[27:24];
            3'd2: w_nibble = r_word[23:20];
            3'd3: w_nibble = r_word[19:16];
            3'd4: w_nibble = r_word[15:12];
            3'd5: w_nibble = r_word[11:8];
            3'd6: w_nibble = r_word[7:4];
            3'd7: w_nibble = r_word[3:0];
            default: w_nibble = r_word[31:28];
        endcase
    end

    assign w_char = hex_ascii(w_nibble);

    // 13-bit arithmetic throughout gives the mod-8192 wrap for free.
    assign w_row  = 13'(BASE_ROW) + 13'(r_reg_idx);
    assign w_addr = (w_row * 13'(COLS)) + {10'd0, r_nib_idx};

    // -------------------------------------------------------------------------
    // Outputs depend only on state and registers, so the asynchronous reset of
    // the state register drops them immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        ascii_write_en      = 1'b0;
        ascii_write_address = '0;
        ascii_input         = '0;
        busy                = (r_state != S_IDLE);
        done                = (r_state == S_DONE);
        if (r_state == S_EMIT) begin
            ascii_write_en      = 1'b1;
            ascii_write_address = w_addr;
            ascii_input         = {w_char, ATTR};
        end
    end

    assign debug_reg = r_debug_reg;

endmodule
